// File: rtl/mux_4_1.sv
// Registered lane selector: picks lane[sel_in] of a packed bus, with valid and range-error flags.
// Define MUX4_1_COMB_OUT_EN to bypass the output register (purely combinational, clk/rst_n unused).
module mux_4_1 #(
  parameter int LANES  = 4,
  parameter int LANE_W = 1,
  parameter int SEL_W  = $clog2(LANES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LANES*LANE_W-1:0] data_in,
  input  logic [SEL_W-1:0]        sel_in,
  input  logic                    in_valid,
  output logic [LANE_W-1:0]       y_out,
  output logic                    out_valid,
  output logic                    sel_err
);

  localparam logic [31:0] LANES_U = 32'(LANES);

  logic [LANE_W-1:0] y_next;
  logic              sel_oor;

  // Equality compare per lane keeps an unknown select from leaking into the data path.
  always_comb begin
    y_next = '0;
    for (int k = 0; k < LANES; k++) begin
      if (sel_in == SEL_W'(k)) begin
        y_next = data_in[k*LANE_W +: LANE_W];
      end
    end
  end

  always_comb begin
    sel_oor = 1'b0;
    if (32'(sel_in) >= LANES_U) begin
      sel_oor = 1'b1;
    end
  end

`ifdef MUX4_1_COMB_OUT_EN
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  assign y_out     = y_next;
  assign out_valid = in_valid;
  assign sel_err   = sel_oor;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_out     <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y_out   <= y_next;
        sel_err <= sel_oor;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mux_4_1.sv
// Bench for mux_4_1: default 4x1-bit instance plus a 3x2-bit instance for out-of-range selects.
module tb_mux_4_1;

  logic       clk;
  logic       rst_n;
  logic [3:0] data_in;
  logic [1:0] sel_in;
  logic       in_valid;
  logic       y_out;
  logic       out_valid;
  logic       sel_err;

  logic [5:0] data3;
  logic [1:0] sel3;
  logic       valid3;
  logic [1:0] y3;
  logic       out_valid3;
  logic       sel_err3;

  int total = 0;
  int bad   = 0;

  logic       exp_y,  exp_v,  exp_e;
  logic [1:0] exp_y3;
  logic       exp_v3, exp_e3;

  mux_4_1 dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .sel_in(sel_in), .in_valid(in_valid),
    .y_out(y_out), .out_valid(out_valid), .sel_err(sel_err)
  );

  mux_4_1 #(.LANES(3), .LANE_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .data_in(data3), .sel_in(sel3), .in_valid(valid3),
    .y_out(y3), .out_valid(out_valid3), .sel_err(sel_err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: shift the bus right by sel lanes and mask one lane; out-of-range gives zero.
  function automatic logic ref4(input logic [3:0] d, input logic [1:0] s);
    int sh;
    sh = int'(s);
    return logic'((int'(d) >> sh) & 1);
  endfunction

  function automatic logic [1:0] ref3(input logic [5:0] d, input logic [1:0] s);
    int sh;
    if (int'(s) >= 3) return 2'b00;
    sh = 2 * int'(s);
    return 2'((int'(d) >> sh) & 3);
  endfunction

  task automatic modelReset();
    exp_y = 1'b0;  exp_v = 1'b0;  exp_e = 1'b0;
    exp_y3 = 2'b0; exp_v3 = 1'b0; exp_e3 = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    total++;
    assert (y_out === exp_y) else begin
      bad++; $error("[TB] FAIL %s y_out: got %b want %b", tag, y_out, exp_y);
    end
    total++;
    assert (out_valid === exp_v) else begin
      bad++; $error("[TB] FAIL %s out_valid: got %b want %b", tag, out_valid, exp_v);
    end
    total++;
    assert (sel_err === exp_e) else begin
      bad++; $error("[TB] FAIL %s sel_err: got %b want %b", tag, sel_err, exp_e);
    end
    total++;
    assert (y3 === exp_y3) else begin
      bad++; $error("[TB] FAIL %s y3: got %b want %b", tag, y3, exp_y3);
    end
    total++;
    assert (out_valid3 === exp_v3) else begin
      bad++; $error("[TB] FAIL %s out_valid3: got %b want %b", tag, out_valid3, exp_v3);
    end
    total++;
    assert (sel_err3 === exp_e3) else begin
      bad++; $error("[TB] FAIL %s sel_err3: got %b want %b", tag, sel_err3, exp_e3);
    end
  endtask

  // Drive both instances, clock once, update the model, then check just after the edge.
  task automatic applyStimulus(input logic v, input logic [3:0] d, input logic [1:0] s,
                               input logic v3, input logic [5:0] d3, input logic [1:0] s3,
                               input string tag);
    in_valid = v;  data_in = d;  sel_in = s;
    valid3   = v3; data3   = d3; sel3   = s3;
    @(posedge clk);
    #1;
    exp_v = v;
    if (v) begin
      exp_y = ref4(d, s);
      exp_e = 1'b0;
    end
    exp_v3 = v3;
    if (v3) begin
      exp_y3 = ref3(d3, s3);
      exp_e3 = (int'(s3) >= 3);
    end
    checkOutput(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b1; data_in = 4'b1111; sel_in = 2'd3;
    valid3 = 1'b1;   data3 = 6'b111111; sel3 = 2'd3;
    modelReset();

    $display("[TB] reset phase");
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("reset");
    end
    rst_n = 1'b1;

    $display("[TB] directed selects");
    applyStimulus(1'b1, 4'd5,  2'd2, 1'b0, 6'd0, 2'd0, "dir_5_s2");
    applyStimulus(1'b1, 4'd15, 2'd3, 1'b0, 6'd0, 2'd0, "dir_15_s3");
    applyStimulus(1'b1, 4'd6,  2'd1, 1'b0, 6'd0, 2'd0, "dir_6_s1");
    applyStimulus(1'b1, 4'd5,  2'd1, 1'b0, 6'd0, 2'd0, "dir_5_s1");

    $display("[TB] hold");
    applyStimulus(1'b1, 4'd6, 2'd1, 1'b0, 6'd0, 2'd0, "hold_load");
    applyStimulus(1'b0, 4'd0, 2'd1, 1'b0, 6'd0, 2'd0, "hold_idle");
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b0, 6'd0, 2'd0, "hold_idle2");

    $display("[TB] out-of-range on 3-lane instance");
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b1, 6'b10_01_11, 2'd3, "oor_s3");
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b0, 6'b00_00_00, 2'd0, "oor_hold");
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b1, 6'b00_00_11, 2'd0, "oor_s0");
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b1, 6'b10_01_11, 2'd2, "oor_s2");
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b1, 6'b10_01_11, 2'd1, "oor_s1");

    $display("[TB] exhaustive back-to-back");
    for (int d = 0; d < 16; d++) begin
      for (int s = 0; s < 4; s++) begin
        applyStimulus(1'b1, 4'(d), 2'(s), 1'b1, 6'(d * 4 + s), 2'(s), "exhaustive");
      end
    end

    $display("[TB] mid-stream reset");
    applyStimulus(1'b1, 4'b1111, 2'd0, 1'b1, 6'b11_11_11, 2'd1, "pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("async_reset");
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'b0100, 2'd2, 1'b1, 6'b01_10_11, 2'd2, "post_reset");
    applyStimulus(1'b1, 4'b1011, 2'd2, 1'b1, 6'b01_10_11, 2'd1, "post_reset2");

    $display("[TB] random");
    for (int i = 0; i < 150; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), 2'($urandom),
                    1'($urandom_range(0, 1)), 6'($urandom), 2'($urandom), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_4_1.md
# mux_4_1

Registered 4-to-1 selector: picks one lane of a packed data bus with a binary select and presents it on a registered output after one clock, alongside a valid flag. It is a leaf datapath block for lane-select paths (e.g. picking one status bit out of four sources). Default configuration is 4 single-bit lanes (`data_in[3:0]`, `sel_in[1:0]`, `y_out`).

## Interface
Parameters:
- `LANES`, default 4: number of input lanes, ≥2.
- `LANE_W`, default 1: width of each lane in bits.
- `SEL_W`, default `$clog2(LANES)`: select width. Derived; do not override.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `data_in`: input, `LANES*LANE_W` bits. Packed lanes; lane k is `data_in[k*LANE_W +: LANE_W]`.
- `sel_in`: input, `SEL_W` bits. Binary lane index.
- `in_valid`: input, 1 bit. Qualifies `data_in` and `sel_in` for this cycle.
- `y_out`: output, `LANE_W` bits. The selected lane.
- `out_valid`: output, 1 bit. `y_out` holds a result from a valid input.
- `sel_err`: output, 1 bit. The last valid select was out of range (`sel_in ≥ LANES`).

## Operation
- Select: `y_next = lane[sel_in]` when `sel_in < LANES`. Otherwise `y_next = 0` and the error is raised.
  - With `LANES` a power of two, every select value is in range and `sel_err` stays 0.
- In a cycle where `in_valid=1`:
  - `y_out <= y_next`
  - `out_valid <= 1`
  - `sel_err <= (sel_in ≥ LANES)`
- In a cycle where `in_valid=0`:
  - `out_valid <= 0`
  - `y_out` and `sel_err` hold their last values.
- There is no back-pressure. A result is produced every cycle that `in_valid` is high.
- Unknown or X on `sel_in` must not propagate beyond the lane compare. Out-of-range decoding uses the explicit compare above.

## Timing
- Reset (`rst_n=0`, asynchronous assert; release synchronous to `clk`): `y_out=0`, `out_valid=0`, `sel_err=0`.
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Throughput: one selection per cycle. Back-to-back valid inputs produce back-to-back valid outputs.
- Reset asserted mid-stream: outputs clear immediately, with no waiting for a clock edge. The first valid input after release appears 1 cycle later.
- Select and data changing in the same cycle as `in_valid`: the new pair is used together; there is no mixing with the previous select.

## Configuration
- `MUX4_1_COMB_OUT_EN` defined: the output register is bypassed.
  - `y_out = y_next` combinationally, with zero latency, regardless of `in_valid`.
  - `out_valid = in_valid`.
  - `sel_err = (sel_in ≥ LANES)`, combinational.
  - `clk` and `rst_n` are unused in this mode.
- `MUX4_1_COMB_OUT_EN` not defined (default): registered behaviour exactly as in Operation and Timing.

## Test plan
- Reset: hold `rst_n=0` with `data_in=4'b1111`, `sel_in=3`, `in_valid=1` -> `y_out=0`, `out_valid=0`, `sel_err=0` throughout reset.
- Directed selects, one per cycle with `in_valid=1`:
  - `data_in=4'd5`, `sel=2` -> `y_out=1`
  - `data_in=4'd15`, `sel=3` -> `y_out=1`
  - `data_in=4'd6`, `sel=1` -> `y_out=1`
  - `data_in=4'd5`, `sel=1` -> `y_out=0`
  - Each result appears 1 cycle after its input, with `out_valid=1`.
- Hold: `data_in=4'd6`, `sel=1`, valid, then `in_valid=0` with `data_in=0` -> `y_out` stays 1 and `out_valid` drops to 0.
- Exhaustive: all 16 data values × 4 selects, `in_valid=1` -> `y_out == data_in[sel]` one cycle later. No `sel_err` in any case.
- Out-of-range select, with `LANES=3`, `LANE_W=2`: `sel=3`, valid -> `y_out=0`, `sel_err=1`. A following `sel=0` with `data_in=6'b00_00_11` -> `y_out=2'b11`, `sel_err=0`.
- Mid-stream reset: stream valid inputs, pulse `rst_n` low between edges -> outputs go to 0 immediately. The first valid input after release appears 1 cycle later.
- Macro build with `MUX4_1_COMB_OUT_EN`: `data_in=4'd5`, `sel=2` -> `y_out=1` in the same cycle, with no clock applied.
